// File: rtl/threemux_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | threemux_pkg: shared types and constants for threemux_arbiter    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package threemux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GRANT  = 2'd2
    } state_t;

    localparam logic [1:0] REQ_A = 2'd0;
    localparam logic [1:0] REQ_B = 2'd1;
    localparam logic [1:0] REQ_D = 2'd2;

    // Select pairs are {s, s1}; D only defines s1, s keeps its old value
    localparam logic [1:0] SEL_A    = 2'b11;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic       SEL_D_S1 = 1'b0;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx >= REQ_D) ? REQ_A : idx + 2'd1;
    endfunction

    function automatic logic [1:0] sel_for(input logic [1:0] idx, input logic s_prev);
        case (idx)
            REQ_A:   return SEL_A;
            REQ_B:   return SEL_B;
            default: return {s_prev, SEL_D_S1};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/threemux_arbiter_rr_pick3.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_pick3: first asserted request scanning ptr, ptr+1, ptr+2      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_pick3
    import threemux_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] win,
    output logic [1:0] win_idx
);

    logic [1:0] w_idx0;
    logic [1:0] w_idx1;
    logic [1:0] w_idx2;

    always_comb begin
        w_idx0  = (ptr > REQ_D) ? REQ_A : ptr;
        w_idx1  = next_idx(w_idx0);
        w_idx2  = next_idx(w_idx1);
        win     = 3'b000;
        win_idx = REQ_A;
        if (req[w_idx0]) begin
            win_idx = w_idx0;
            win     = 3'b001 << w_idx0;
        end else if (req[w_idx1]) begin
            win_idx = w_idx1;
            win     = 3'b001 << w_idx1;
        end else if (req[w_idx2]) begin
            win_idx = w_idx2;
            win     = 3'b001 << w_idx2;
        end
    end

endmodule
`default_nettype wire

// File: rtl/threemux_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | threemux_arbiter: round-robin owner of the shared threemux path  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module threemux_arbiter
    import threemux_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int HOLD_MAX      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic       s,
    output logic       s1,
    output logic       out_valid,
    output logic       busy
);

    localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);
    localparam logic [HW-1:0] HOLD_LIMIT  = HW'(HOLD_MAX);
    // The first valid cycle already counts toward the hold budget
    localparam logic [HW-1:0] HOLD_FIRST  = (HOLD_MAX > 0) ? HW'(1) : '0;

    state_t        r_state;
    logic [1:0]    r_ptr;
    logic [1:0]    r_win_idx;
    logic [SW-1:0] r_settle_cnt;
    logic [HW-1:0] r_hold_cnt;

    logic [2:0]    w_pick_req;
    logic [1:0]    w_pick_ptr;
    logic [2:0]    w_pick_win;
    logic [1:0]    w_pick_idx;
    logic          w_owner_req;
    logic          w_hold_expired;
    logic          w_release;
    logic          w_start;

    // While busy the picker looks past the current owner for a successor
    always_comb begin
        w_owner_req    = |(req & gnt);
        w_hold_expired = (HOLD_MAX != 0) && (r_hold_cnt == HOLD_LIMIT) && (|(req & ~gnt));
        w_release      = ((r_state == ST_SETTLE) && !w_owner_req) ||
                         ((r_state == ST_GRANT) && (!w_owner_req || w_hold_expired));
        w_pick_ptr     = busy ? next_idx(r_win_idx) : r_ptr;
        w_pick_req     = busy ? (req & ~gnt) : req;
        w_start        = ((r_state == ST_IDLE) && (|req)) || (w_release && (|w_pick_req));
    end

    rr_pick3 u_pick (
        .req     (w_pick_req),
        .ptr     (w_pick_ptr),
        .win     (w_pick_win),
        .win_idx (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= REQ_A;
            r_win_idx    <= REQ_A;
            r_settle_cnt <= '0;
            r_hold_cnt   <= '0;
            gnt          <= 3'b000;
            s            <= 1'b0;
            s1           <= 1'b0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (w_release) begin
                r_ptr      <= w_pick_ptr;
                r_hold_cnt <= '0;
                r_state    <= ST_IDLE;
                gnt        <= 3'b000;
                out_valid  <= 1'b0;
                busy       <= 1'b0;
            end else if (r_state == ST_SETTLE) begin
                if (r_settle_cnt <= SW'(1)) begin
                    r_state    <= ST_GRANT;
                    out_valid  <= 1'b1;
                    r_hold_cnt <= HOLD_FIRST;
                end else begin
                    r_settle_cnt <= r_settle_cnt - SW'(1);
                end
            end else if ((r_state == ST_GRANT) && (r_hold_cnt != HOLD_LIMIT)) begin
                r_hold_cnt <= r_hold_cnt + HW'(1);
            end

            // A new grant overrides the release defaults above
            if (w_start) begin
                gnt       <= w_pick_win;
                r_win_idx <= w_pick_idx;
                {s, s1}   <= sel_for(w_pick_idx, s);
                busy      <= 1'b1;
                if (SETTLE_CYCLES == 0) begin
                    r_state    <= ST_GRANT;
                    out_valid  <= 1'b1;
                    r_hold_cnt <= HOLD_FIRST;
                end else begin
                    r_state      <= ST_SETTLE;
                    out_valid    <= 1'b0;
                    r_settle_cnt <= SETTLE_LOAD;
                end
            end
        end
    end

endmodule
`default_nettype wire
